// File: rtl/tmp_bitstream_decim_if.sv
// Output word channel of the bitstream decimator: ones count plus valid/ready handshake.
interface tmp_bitstream_decim_if #(
  parameter int OSR_LOG2 = 6
);
  logic [OSR_LOG2:0] code;
  logic              code_valid;
  logic              code_ready;

  modport master (output code, output code_valid, input code_ready);
  modport slave  (input code, input code_valid, output code_ready);
endinterface

// File: rtl/tmp_bitstream_decim.sv
// Ones-counting decimator for the temperature-sensor comparator bitstream:
// settling discard, windowed accumulation and a single-word output register with overrun flag.
module tmp_bitstream_decim #(
  parameter int OSR_LOG2 = 6,
  parameter int DISCARD  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         sample,
  input  logic                         bit_in,
  tmp_bitstream_decim_if.master        bus,
  output logic                         overrun,
  input  logic                         clear_ovr,
  output logic                         busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_t;

  localparam int DISC_LAST = (DISCARD > 0) ? DISCARD - 1 : 0;

  state_t              state, state_nxt;
  logic [OSR_LOG2:0]   acc;
  logic [OSR_LOG2-1:0] cnt;
  logic [3:0]          disc_cnt;

  logic                done_p0;
  logic [OSR_LOG2:0]   res_p0;
  logic                load_p0;

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = (DISCARD > 0) ? SETTLE : ACCUM;
        SETTLE:  if (sample && disc_cnt == 4'(DISC_LAST)) state_nxt = ACCUM;
        ACCUM:   state_nxt = ACCUM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stage p0: last decision of a window completes combinationally with the strobe
  assign done_p0 = enable && (state == ACCUM) && sample && (cnt == {OSR_LOG2{1'b1}});
  assign res_p0  = acc + {{OSR_LOG2{1'b0}}, bit_in};
  assign load_p0 = done_p0 && (!bus.code_valid || bus.code_ready);

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      acc      <= '0;
      cnt      <= '0;
      disc_cnt <= '0;
    end else begin
      case (state)
        SETTLE: if (sample) begin
          disc_cnt <= (disc_cnt == 4'(DISC_LAST)) ? 4'd0 : disc_cnt + 4'd1;
        end
        ACCUM: if (sample) begin
          if (cnt == {OSR_LOG2{1'b1}}) begin
            acc <= '0;
            cnt <= '0;
          end else begin
            acc <= res_p0;
            cnt <= cnt + OSR_LOG2'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p1: output register; a completing window either loads or is counted as overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.code       <= '0;
      bus.code_valid <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (load_p0) begin
        bus.code       <= res_p0;
        bus.code_valid <= 1'b1;
      end else if (bus.code_valid && bus.code_ready) begin
        bus.code_valid <= 1'b0;
      end
      if (done_p0 && !load_p0) overrun <= 1'b1;
      else if (clear_ovr)      overrun <= 1'b0;
    end
  end

  assign busy = (state == SETTLE) || (state == ACCUM);

endmodule

// File: tb/tb_tmp_bitstream_decim.sv
// Directed bench for tmp_bitstream_decim with OSR_LOG2=3, DISCARD=2.
module tb_tmp_bitstream_decim;

  localparam int OSR_LOG2 = 3;
  localparam int DISCARD  = 2;

  logic clk = 1'b0;
  logic reset, enable, sample, bit_in, clear_ovr;
  logic overrun, busy;

  tmp_bitstream_decim_if #(.OSR_LOG2(OSR_LOG2)) bus ();

  tmp_bitstream_decim #(.OSR_LOG2(OSR_LOG2), .DISCARD(DISCARD)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sample    (sample),
    .bit_in    (bit_in),
    .bus       (bus),
    .overrun   (overrun),
    .clear_ovr (clear_ovr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] pat;
    int         gap;
    int         exp;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic strobe(input logic b);
    sample = 1'b1;
    bit_in = b;
    tick();
    sample = 1'b0;
    bit_in = 1'b0;
  endtask

  // Sends bits pat[7] first, pat[0] last.
  task automatic window(input logic [7:0] pat);
    for (int i = 7; i >= 0; i--) strobe(pat[i]);
  endtask

  task automatic settle();
    enable = 1'b1;
    tick();
    for (int i = 0; i < DISCARD; i++) strobe(1'b1);
  endtask

  initial begin
    vecs[0] = '{pat: 8'b1011_0010, gap: 0, exp: 4};
    vecs[1] = '{pat: 8'b1111_1111, gap: 0, exp: 8};
    vecs[2] = '{pat: 8'b0000_0000, gap: 0, exp: 0};
    vecs[3] = '{pat: 8'b1000_0001, gap: 1, exp: 2};
    vecs[4] = '{pat: 8'b0111_1111, gap: 2, exp: 7};

    reset = 1'b1; enable = 1'b0; sample = 1'b0; bit_in = 1'b0; clear_ovr = 1'b0;
    bus.code_ready = 1'b1;
    tick(); tick();
    check("rst_code", int'(bus.code), 0);
    check("rst_valid", int'(bus.code_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    tick();

    // Table: discard strobes carry ones that must not be counted.
    for (int v = 0; v < 5; v++) begin
      enable = 1'b1;
      tick();
      check("vec_busy", int'(busy), 1);
      for (int i = 0; i < DISCARD; i++) strobe(1'b1);
      for (int i = 7; i >= 0; i--) begin
        strobe(vecs[v].pat[i]);
        if (i > 0) repeat (vecs[v].gap) tick();
      end
      check("vec_code", int'(bus.code), vecs[v].exp);
      check("vec_valid", int'(bus.code_valid), 1);
      tick();
      check("vec_consumed", int'(bus.code_valid), 0);
      enable = 1'b0;
      tick();
      check("vec_idle_busy", int'(busy), 0);
    end

    // Strobe on the enable-rise cycle is ignored.
    enable = 1'b1; sample = 1'b1; bit_in = 1'b1;
    tick();
    sample = 1'b0; bit_in = 1'b0;
    for (int i = 0; i < DISCARD; i++) strobe(1'b1);
    for (int i = 0; i < 7; i++) strobe(1'b0);
    check("rise_no_early", int'(bus.code_valid), 0);
    strobe(1'b0);
    check("rise_code", int'(bus.code), 0);
    check("rise_valid", int'(bus.code_valid), 1);
    tick();
    enable = 1'b0;
    tick();

    // Back-pressure: second window overruns, first code held.
    bus.code_ready = 1'b0;
    settle();
    window(8'b1110_0000);
    check("bp_code1", int'(bus.code), 3);
    check("bp_valid1", int'(bus.code_valid), 1);
    check("bp_ovr1", int'(overrun), 0);
    window(8'b1111_1000);
    check("bp_code2", int'(bus.code), 3);
    check("bp_valid2", int'(bus.code_valid), 1);
    check("bp_ovr2", int'(overrun), 1);
    clear_ovr = 1'b1;
    tick();
    clear_ovr = 1'b0;
    check("clr_ovr", int'(overrun), 0);
    check("clr_code", int'(bus.code), 3);

    // Consume and load on the same edge.
    for (int i = 7; i >= 1; i--) strobe(1'b1);
    bus.code_ready = 1'b1;
    strobe(1'b0);
    check("swap_code", int'(bus.code), 7);
    check("swap_valid", int'(bus.code_valid), 1);
    check("swap_ovr", int'(overrun), 0);
    tick();
    check("swap_drain", int'(bus.code_valid), 0);
    bus.code_ready = 1'b0;

    // Overrun set wins over a simultaneous clear.
    window(8'b1100_0000);
    check("sw_code", int'(bus.code), 2);
    for (int i = 7; i >= 1; i--) strobe(1'b0);
    clear_ovr = 1'b1;
    strobe(1'b1);
    clear_ovr = 1'b0;
    check("sw_ovr", int'(overrun), 1);
    check("sw_code_held", int'(bus.code), 2);
    clear_ovr = 1'b1;
    tick();
    clear_ovr = 1'b0;
    check("sw_cleared", int'(overrun), 0);

    // Partial window abandoned when enable drops.
    for (int i = 0; i < 5; i++) strobe(1'b1);
    enable = 1'b0;
    tick();
    check("drop_busy", int'(busy), 0);
    check("drop_code", int'(bus.code), 2);
    check("drop_valid", int'(bus.code_valid), 1);
    settle();
    for (int i = 0; i < 7; i++) strobe(i < 3);
    check("re_hold_code", int'(bus.code), 2);
    check("re_hold_ovr", int'(overrun), 0);
    bus.code_ready = 1'b1;
    strobe(1'b0);
    bus.code_ready = 1'b0;
    check("re_code", int'(bus.code), 3);
    check("re_valid", int'(bus.code_valid), 1);
    check("re_ovr", int'(overrun), 0);

    // Mid-window reset with a pending code and overrun set.
    window(8'b0000_0000);
    check("pre_rst_ovr", int'(overrun), 1);
    for (int i = 0; i < 3; i++) strobe(1'b1);
    reset = 1'b1;
    tick();
    check("mrst_code", int'(bus.code), 0);
    check("mrst_valid", int'(bus.code_valid), 0);
    check("mrst_ovr", int'(overrun), 0);
    check("mrst_busy", int'(busy), 0);
    reset = 1'b0; enable = 1'b0;
    for (int i = 0; i < 3; i++) strobe(1'b1);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_valid", int'(bus.code_valid), 0);
    settle();
    window(8'b1111_1111);
    check("post_rst_code", int'(bus.code), 8);
    check("post_rst_vld", int'(bus.code_valid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmp_bitstream_decim.md
Name: tmp_bitstream_decim

Overview:
- Downstream of the temperature-sensor phase controller.
- Consumes its per-conversion comparator decision bitstream and accumulates ones over a window of 2^OSR_LOG2 decisions.
- Presents the count as a digital temperature code to the register/readout logic over a valid/ready handshake.
- Discards a configurable number of settling decisions after each enable and flags results lost to back-pressure.

Parameters:
- OSR_LOG2, 6, log2 of decisions per output word (window = 2^OSR_LOG2); legal range 2..10.
- DISCARD, 2, decisions dropped after enable rises before the first window starts; legal range 0..15.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  conversion enable; low forces IDLE.
- sample  input  1  one-cycle strobe from the controller: bit_in is a valid decision this cycle.
- bit_in  input  1  comparator decision (1 = ones count).
- code  output  OSR_LOG2+1  accumulated ones count of the last completed window, range 0..2^OSR_LOG2.
- code_valid  output  1  code holds an unconsumed word.
- code_ready  input  1  consumer accepts code when code_valid & code_ready.
- overrun  output  1  sticky: a completed window was dropped because the output was still full.
- clear_ovr  input  1  clears overrun.
- busy  output  1  high in SETTLE or ACCUM.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state IDLE;
  - code = 0, code_valid = 0, overrun = 0, busy = 0;
  - internal accumulator, sample counter and discard counter = 0.
- States:
  - IDLE: sample is ignored. On enable=1, go to SETTLE if DISCARD>0, else go to ACCUM.
  - SETTLE: each sample strobe increments the discard counter. On the strobe that brings it to DISCARD, go to ACCUM with accumulator and counter at 0. bit_in is never accumulated in SETTLE.
  - ACCUM: each sample strobe adds bit_in to the accumulator and increments the sample counter (OSR_LOG2 bits).
    - On the strobe where the counter reaches 2^OSR_LOG2-1 (last decision of the window), the window result is accumulator + bit_in.
    - On that same strobe, accumulator and counter reset to 0 and ACCUM continues. There is no gap: the next strobe is decision 0 of the new window.
- Any state, enable=0: next state IDLE.
  - Accumulator, sample counter and discard counter clear.
  - A partial window is discarded.
  - code, code_valid and overrun are retained.
- Output register and handshake:
  - Result latency: code/code_valid update on the clock edge following the completing strobe, i.e. visible the cycle after sample.
  - Handshake completes on a cycle with code_valid & code_ready. code_valid drops next cycle unless a new result loads on that same edge.
  - A result loads if code_valid=0, or if code_ready=1 in the completing cycle (simultaneous consume + load: code_valid stays 1 and code takes the new value).
  - Otherwise the result is dropped, code is unchanged, and overrun is set.
  - code is held stable while code_valid=1 and code_ready=0.
- overrun:
  - clear_ovr=1 clears it.
  - If a set and a clear occur in the same cycle, the set wins.
- sample while state transitions: a strobe on the cycle enable rises is ignored (IDLE), so the first counted strobe is the next one.
- Width: the accumulator is OSR_LOG2+1 bits, so an all-ones window yields exactly 2^OSR_LOG2 without wrap.
- busy = (state==SETTLE) | (state==ACCUM).
- Mid-operation reset: same as power-up reset; a pending code is lost.

Test Plan:
- OSR_LOG2=3, DISCARD=2, code_ready=1: enable, 2 strobes with bit_in=1, then 8 strobes with pattern 1,0,1,1,0,0,1,0 -> the discarded ones are not counted; code=4, code_valid pulses 1 cycle after the 8th strobe.
- All-ones window (OSR_LOG2=3, 8 strobes bit_in=1) -> code=8 (4'b1000), no wrap. All-zeros window -> code=0 with code_valid=1.
- code_ready=0, two full windows (counts 3 then 5) -> code stays 3, code_valid stays 1, overrun=1 after the second window. Pulse clear_ovr -> overrun=0 next cycle; code still 3.
- Simultaneous consume and load: code_ready=1 on the exact cycle the 2nd window completes -> code switches from the first to the second count, code_valid stays 1, overrun=0.
- enable dropped after 5 of 8 strobes, then re-raised -> the partial window is discarded, DISCARD strobes are skipped again, and the next code reflects only the new 8 decisions. The prior code/code_valid is unchanged throughout.
- reset asserted with code_valid=1 and overrun=1, 3 strobes into a window -> next cycle all outputs are 0, state is IDLE, and sample strobes are ignored until enable is seen high after reset deasserts.
